// File: rtl/decode_queue_if.sv
// Fetch-side handshake, flush and decoded rename-side payload of decode_queue.
interface decode_queue_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PC_W  = 9,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             flush;
   logic             i_valid;
   logic             i_ready;
   logic [31:0]      i_instr;
   logic [PC_W-1:0]  i_pc;
   logic             o_valid;
   logic             o_ready;
   logic [PC_W-1:0]  o_pc;
   logic [4:0]       o_rs1;
   logic [4:0]       o_rs2;
   logic [4:0]       o_rd;
   logic [XLEN-1:0]  o_immediate;
   logic             o_ALUsrc;
   logic             o_Branch;
   logic [1:0]       o_ALUOp;
   logic [1:0]       o_FUtype;
   logic             o_Memread;
   logic             o_Memwrite;
   logic             o_Regwrite;
   logic [2:0]       o_funct3;
   logic             o_funct7b5;
   logic             o_illegal;
   logic [CNT_W-1:0] o_count;

   modport master (
      output flush, i_valid, i_instr, i_pc, o_ready,
      input  i_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_immediate,
             o_ALUsrc, o_Branch, o_ALUOp, o_FUtype, o_Memread, o_Memwrite,
             o_Regwrite, o_funct3, o_funct7b5, o_illegal, o_count
   );

   modport slave (
      input  flush, i_valid, i_instr, i_pc, o_ready,
      output i_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_immediate,
             o_ALUsrc, o_Branch, o_ALUOp, o_FUtype, o_Memread, o_Memwrite,
             o_Regwrite, o_funct3, o_funct7b5, o_illegal, o_count
   );
endinterface

// File: rtl/decode_queue.sv
// RV32I decoder feeding a DEPTH-entry elastic queue toward rename.
// Handles flush, illegal opcodes, x0-write suppression and reports occupancy.
module decode_queue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PC_W  = 9,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   decode_queue_if.slave dq
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            alu_src;
      logic            branch;
      logic [1:0]      alu_op;
      logic [1:0]      fu_type;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            illegal;
   } entry_t;

   logic [31:0]        instr;
   logic [6:0]         opcode;
   logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
   logic               use_rs1, use_rs2, use_rd;
   entry_t             dec_c;

   entry_t             mem [DEPTH];
   entry_t             head_c;
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ready_q, valid_q;
   logic               push_c, pop_c;

   assign instr  = dq.i_instr;
   assign opcode = instr[6:0];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Full decode of the incoming word; unused register fields are forced to zero.
   always_comb begin
      dec_c          = '0;
      imm_sel        = '0;
      use_rs1        = 1'b0;
      use_rs2        = 1'b0;
      use_rd         = 1'b0;
      dec_c.pc       = dq.i_pc;
      dec_c.funct3   = instr[14:12];
      dec_c.funct7b5 = instr[30];
      case (opcode)
         OP_R: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            dec_c.alu_op    = 2'b10;
            dec_c.reg_write = 1'b1;
         end
         OP_IMM: begin
            use_rs1 = 1'b1; use_rd = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.alu_op    = 2'b10;
            dec_c.reg_write = 1'b1;
            imm_sel         = imm_i;
         end
         OP_LOAD: begin
            use_rs1 = 1'b1; use_rd = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.fu_type   = 2'b10;
            dec_c.mem_read  = 1'b1;
            dec_c.reg_write = 1'b1;
            imm_sel         = imm_i;
         end
         OP_STORE: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.fu_type   = 2'b10;
            dec_c.mem_write = 1'b1;
            imm_sel         = imm_s;
         end
         OP_BRANCH: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            dec_c.branch  = 1'b1;
            dec_c.alu_op  = 2'b01;
            dec_c.fu_type = 2'b01;
            imm_sel       = imm_b;
         end
         OP_LUI: begin
            use_rd = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.alu_op    = 2'b11;
            dec_c.reg_write = 1'b1;
            imm_sel         = imm_u;
         end
         OP_AUIPC: begin
            use_rd = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.reg_write = 1'b1;
            imm_sel         = imm_u;
         end
         OP_JAL: begin
            use_rd = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.branch    = 1'b1;
            dec_c.fu_type   = 2'b01;
            dec_c.reg_write = 1'b1;
            imm_sel         = imm_j;
         end
         OP_JALR: begin
            use_rs1 = 1'b1; use_rd = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.branch    = 1'b1;
            dec_c.fu_type   = 2'b01;
            dec_c.reg_write = 1'b1;
            imm_sel         = imm_i;
         end
         default: begin
            dec_c.illegal = 1'b1;
            dec_c.fu_type = 2'b11;
         end
      endcase
      dec_c.rs1 = use_rs1 ? instr[19:15] : 5'd0;
      dec_c.rs2 = use_rs2 ? instr[24:20] : 5'd0;
      dec_c.rd  = use_rd  ? instr[11:7]  : 5'd0;
      dec_c.imm = XLEN'(imm_sel);
      // Writes to x0 are architecturally discarded, so rename never allocates for them.
      if (dec_c.rd == 5'd0) dec_c.reg_write = 1'b0;
   end

   assign push_c = dq.i_valid && ready_q && !dq.flush && !rst;
   assign pop_c  = valid_q && dq.o_ready && !dq.flush && !rst;

   // Next pointer/occupancy; flush discards any same-cycle push or pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (dq.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_c) tail_d = tail_q + PTR_W'(1);
         if (pop_c)  head_d = head_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // i_ready and o_valid are registered copies of the next occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ready_q <= (count_d < CNT_W'(DEPTH));
         valid_q <= (count_d != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[tail_q] <= dec_c;
   end

   assign head_c = valid_q ? mem[head_q] : '0;

   assign dq.i_ready     = ready_q;
   assign dq.o_valid     = valid_q;
   assign dq.o_count     = count_q;
   assign dq.o_pc        = head_c.pc;
   assign dq.o_rs1       = head_c.rs1;
   assign dq.o_rs2       = head_c.rs2;
   assign dq.o_rd        = head_c.rd;
   assign dq.o_immediate = head_c.imm;
   assign dq.o_ALUsrc    = head_c.alu_src;
   assign dq.o_Branch    = head_c.branch;
   assign dq.o_ALUOp     = head_c.alu_op;
   assign dq.o_FUtype    = head_c.fu_type;
   assign dq.o_Memread   = head_c.mem_read;
   assign dq.o_Memwrite  = head_c.mem_write;
   assign dq.o_Regwrite  = head_c.reg_write;
   assign dq.o_funct3    = head_c.funct3;
   assign dq.o_funct7b5  = head_c.funct7b5;
   assign dq.o_illegal   = head_c.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: two instances (DEPTH 2 and 4) fed from one program list.
module tb_decode_queue;
   localparam int unsigned XLEN = 32;
   localparam int unsigned PC_W = 9;
   localparam logic [6:0] OPC_IMM = 7'b0010011;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [31:0]     imm;
      logic            alusrc;
      logic            branch;
      logic [1:0]      aluop;
      logic [1:0]      futype;
      logic            memread;
      logic            memwrite;
      logic            regwrite;
      logic [2:0]      f3;
      logic            f7b5;
      logic            illegal;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0]     prog_instr[$];
   logic [PC_W-1:0] prog_pc[$];
   logic flush_t  = 1'b0;
   int   rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random
   int   vld_mode = 1;   // 1 present whenever pending, 2 random gaps

   task automatic chk(int ln, string nm, logic [127:0] act, logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL lane%0d %s @%0t: got %h, expected %h", ln, nm, $time, act, req);
      end
   endtask

   // Reference decode straight from the opcode table and immediate bit maps.
   function automatic exp_t ref_decode(logic [31:0] w, logic [PC_W-1:0] pc);
      exp_t   e;
      logic [8:0] ctl;
      bit     u1, u2, ud;
      int     kind;    // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
      longint v;
      e = '0; e.pc = pc; e.f3 = w[14:12]; e.f7b5 = w[30];
      u1 = 1; u2 = 0; ud = 1; kind = 0;
      case (w[6:0])
         7'b0110011: begin ctl = 9'b1_0_10_00_0_0_1; ctl[8] = 0; u2 = 1; end
         7'b0010011: begin ctl = 9'b1_0_10_00_0_0_1; kind = 1; end
         7'b0000011: begin ctl = 9'b1_0_00_10_1_0_1; kind = 1; end
         7'b0100011: begin ctl = 9'b1_0_00_10_0_1_0; u2 = 1; ud = 0; kind = 2; end
         7'b1100011: begin ctl = 9'b0_1_01_01_0_0_0; u2 = 1; ud = 0; kind = 3; end
         7'b0110111: begin ctl = 9'b1_0_11_00_0_0_1; u1 = 0; kind = 4; end
         7'b0010111: begin ctl = 9'b1_0_00_00_0_0_1; u1 = 0; kind = 4; end
         7'b1101111: begin ctl = 9'b1_1_00_01_0_0_1; u1 = 0; kind = 5; end
         7'b1100111: begin ctl = 9'b1_1_00_01_0_0_1; kind = 1; end
         default:    begin ctl = 9'b0_0_00_11_0_0_0; u1 = 0; ud = 0; e.illegal = 1; end
      endcase
      {e.alusrc, e.branch, e.aluop, e.futype, e.memread, e.memwrite, e.regwrite} = ctl;
      e.rs1 = u1 ? w[19:15] : 5'd0;
      e.rs2 = u2 ? w[24:20] : 5'd0;
      e.rd  = ud ? w[11:7]  : 5'd0;
      v = 0;
      case (kind)
         1: begin v = longint'(w[31:20]); if (v >= 2048) v -= 4096; end
         2: begin v = longint'(w[31:25]) * 32 + longint'(w[11:7]); if (v >= 2048) v -= 4096; end
         3: begin
            v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
              + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            if (v >= 4096) v -= 8192;
         end
         4: v = longint'(w & 32'hFFFF_F000);
         5: begin
            v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
              + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            if (v >= 1048576) v -= 2097152;
         end
         default: v = 0;
      endcase
      e.imm = 32'(v);
      if (e.rd == 5'd0) e.regwrite = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      logic [11:0] m;
      m = 12'(imm);
      return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(int off, int rs2, int rs1, int f3);
      logic [12:0] m;
      m = 13'(off);
      return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(int up, int rd, logic [6:0] op);
      return {20'(up), 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_j(int off, int rd);
      logic [20:0] m;
      m = 21'(off);
      return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'b1101111};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 9))
         0: w[6:0] = 7'b0110011;
         1: w[6:0] = 7'b0010011;
         2: w[6:0] = 7'b0000011;
         3: w[6:0] = 7'b0100011;
         4: w[6:0] = 7'b1100011;
         5: w[6:0] = 7'b0110111;
         6: w[6:0] = 7'b0010111;
         7: w[6:0] = 7'b1101111;
         8: w[6:0] = 7'b1100111;
         default: ;
      endcase
      return w;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int unsigned D = (g == 0) ? 2 : 4;

      decode_queue_if #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(D)) bus ();
      decode_queue #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(D)) dut (
         .clk (clk),
         .rst (rst),
         .dq  (bus)
      );

      exp_t exp_q[$];
      exp_t act;
      int   idx   = 0;
      int   cnt_m = 0;
      bit   rdy_m = 0;
      bit   live  = 0;
      bit   push_m, pop_m;

      // Fetch driver and occupancy model; accepted words go to the scoreboard.
      initial begin
         bus.flush = 1'b0; bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_pc = '0; bus.o_ready = 1'b0;
         forever begin
            @(posedge clk);
            live = 1;
            if (rst) begin
               exp_q.delete(); cnt_m = 0; rdy_m = 0; idx = prog_instr.size();
            end else if (bus.flush) begin
               exp_q.delete(); cnt_m = 0; rdy_m = 1;
               if (bus.i_valid) idx++;
            end else begin
               pop_m  = (cnt_m > 0) && bus.o_ready;
               push_m = bus.i_valid && rdy_m;
               if (push_m) begin
                  exp_q.push_back(ref_decode(bus.i_instr, bus.i_pc));
                  idx++;
               end
               cnt_m = cnt_m + int'(push_m) - int'(pop_m);
               rdy_m = (cnt_m < D);
            end
            #2;
            bus.flush = flush_t;
            case (rdy_mode)
               0:       bus.o_ready = 1'b0;
               1:       bus.o_ready = 1'b1;
               default: bus.o_ready = 1'($urandom_range(0, 1));
            endcase
            if (idx < prog_instr.size() && (vld_mode == 1 || $urandom_range(0, 3) != 0)) begin
               bus.i_valid = 1'b1;
               bus.i_instr = prog_instr[idx];
               bus.i_pc    = prog_pc[idx];
            end else begin
               bus.i_valid = 1'b0;
            end
         end
      end

      // Monitor: compares whatever the head presents and retires it on handshake.
      always @(negedge clk) begin
         if (live) begin
            chk(g, "o_valid", bus.o_valid, cnt_m != 0);
            chk(g, "i_ready", bus.i_ready, rdy_m);
            chk(g, "o_count", bus.o_count, cnt_m);
            act = '0;
            act.pc = bus.o_pc; act.rs1 = bus.o_rs1; act.rs2 = bus.o_rs2; act.rd = bus.o_rd;
            act.imm = bus.o_immediate; act.alusrc = bus.o_ALUsrc; act.branch = bus.o_Branch;
            act.aluop = bus.o_ALUOp; act.futype = bus.o_FUtype; act.memread = bus.o_Memread;
            act.memwrite = bus.o_Memwrite; act.regwrite = bus.o_Regwrite; act.f3 = bus.o_funct3;
            act.f7b5 = bus.o_funct7b5; act.illegal = bus.o_illegal;
            if (bus.o_valid) begin
               if (exp_q.size() == 0) begin
                  chk(g, "unexpected_entry", act, '1);
               end else begin
                  chk(g, "payload", act, exp_q[0]);
                  if (bus.o_ready && !bus.flush && !rst) void'(exp_q.pop_front());
               end
            end else begin
               chk(g, "idle_payload", act, '0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(logic [31:0] w, int pc);
      prog_instr.push_back(w);
      prog_pc.push_back(PC_W'(pc));
   endtask

   task automatic drain(string nm);
      int t;
      t = 0;
      while (!(lane[0].idx == prog_instr.size() && lane[1].idx == prog_instr.size()
               && lane[0].cnt_m == 0 && lane[1].cnt_m == 0) && t < 3000) begin
         step();
         t++;
      end
      n_cmp++;
      if (t >= 3000) begin
         n_bad++;
         $display("FAIL drain_%s: queues not empty after %0d cycles, expected empty", nm, t);
      end
      repeat (2) step();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      add(enc_r(0, 3, 2, 0, 1), 0);                 // ADD x1,x2,x3
      add(enc_i(100, 5, 0, 4, OPC_IMM), 4);         // ADDI x4,x5,100
      drain("basic");

      add(enc_i(8, 7, 2, 6, 7'b0000011), 0);        // LW x6,8(x7)
      add(enc_s(12, 8, 9, 2), 4);                   // SW x8,12(x9)
      add(enc_b(16, 11, 10, 0), 8);                 // BEQ x10,x11,16
      add(enc_u(32'h12345, 12, 7'b0110111), 12);    // LUI x12,0x12345
      add(enc_u(32'h01000, 13, 7'b0010111), 16);    // AUIPC x13 -> 0x01000000
      add(enc_j(32, 14), 20);                       // JAL x14,32
      add(enc_i(8, 16, 0, 15, 7'b1100111), 24);     // JALR x15,8(x16)
      add(enc_b(-4, 11, 10, 0), 28);                // BEQ offset -4
      add(enc_j(-8, 1), 32);                        // JAL offset -8
      add(enc_s(-20, 3, 4, 0), 36);                 // SB negative offset
      drain("sweep");

      rdy_mode = 0;
      add(enc_i(1, 1, 0, 2, OPC_IMM), 0);
      add(enc_i(2, 1, 0, 3, OPC_IMM), 4);
      add(enc_i(3, 1, 0, 4, OPC_IMM), 8);
      repeat (5) step();
      rdy_mode = 1;
      drain("backpressure");

      rdy_mode = 0;
      for (int i = 0; i < 6; i++) add(enc_r(32, i, i + 1, 0, i + 5), 4 * i);
      repeat (8) step();
      rdy_mode = 1;
      drain("backpressure_wrap");

      rdy_mode = 0;
      add(enc_r(0, 1, 2, 0, 3), 16);
      add(enc_r(0, 4, 5, 0, 6), 20);
      repeat (4) step();
      flush_t = 1'b1;
      add(enc_r(0, 7, 8, 0, 9), 24);
      step();
      flush_t = 1'b0;
      add(enc_i(-7, 10, 0, 11, OPC_IMM), 64);
      rdy_mode = 1;
      drain("flush");

      add(32'hFFFF_FFFF, 100);
      add(enc_i(5, 1, 0, 0, OPC_IMM), 104);          // ADDI x0,x1,5
      add(enc_j(40, 0), 108);                        // JAL x0 -> no regwrite
      drain("illegal_x0");

      rdy_mode = 0;
      for (int i = 0; i < 5; i++) add(enc_i(i, 2, 0, 3, OPC_IMM), 200 + 4 * i);
      repeat (6) step();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      rdy_mode = 1;
      add(enc_r(0, 7, 6, 0, 5), 300);
      drain("reset_midstream");

      rdy_mode = 2;
      vld_mode = 2;
      for (int i = 0; i < 250; i++) add(rand_instr(), 4 * i);
      for (int i = 0; i < 400; i++) begin
         flush_t = ($urandom_range(0, 49) == 0);
         step();
      end
      flush_t  = 1'b0;
      rdy_mode = 1;
      drain("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised RV32I decode stage with a built-in elastic output queue, sitting between instruction fetch (instruction BRAM output) and rename. Each accepted instruction word is fully decoded: register indices, sign-extended immediate, ALUsrc/Branch/ALUOp/FUtype/Mem/Regwrite controls and an illegal-instruction flag. The result is pushed into a DEPTH-entry FIFO. Compared with the single-entry decoder-plus-external-skid arrangement, this block adds:
- configurable buffering depth;
- pipeline flush;
- illegal-opcode detection;
- x0-write suppression;
- an occupancy count.

## Interface
- XLEN, 32: immediate/data width; must be ≥ 32; immediates sign-extend to XLEN.
- PC_W, 9: PC width carried alongside each instruction.
- DEPTH, 2: queue entries; power of two, ≥ 2.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous queue flush (mispredict/redirect).
- i_valid  in  1  fetch has an instruction.
- i_ready  out  1  queue can accept this cycle.
- i_instr  in  32  RV32I instruction word.
- i_pc  in  PC_W  PC of i_instr.
- o_valid  out  1  head entry valid.
- o_ready  in  1  rename accepts head.
- o_pc  out  PC_W  head PC.
- o_rs1, o_rs2, o_rd  out  5 each  register indices.
- o_immediate  out  XLEN  decoded immediate.
- o_ALUsrc, o_Branch  out  1 each  control bits.
- o_ALUOp  out  2  ALU operation class.
- o_FUtype  out  2  00 ALU, 01 Branch, 10 LSU, 11 none/illegal.
- o_Memread, o_Memwrite, o_Regwrite  out  1 each  control bits.
- o_funct3  out  3  instr[14:12].
- o_funct7b5  out  1  instr[30].
- o_illegal  out  1  unrecognised opcode.
- o_count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- **Push:** occurs on i_valid && i_ready && !flush && !rst. Decode is combinational on i_instr; the decoded bundle plus i_pc is written at the tail.
- **Pop:** occurs on o_valid && o_ready && !flush && !rst.
- **Decode table** (ALUsrc, Branch, ALUOp, FUtype, Memread, Memwrite, Regwrite):
  - R 0110011: 0,0,10,00,0,0,1; rs1, rs2, rd used; imm 0.
  - I-ALU 0010011: 1,0,10,00,0,0,1; rs2 = 0.
  - LOAD 0000011: 1,0,00,10,1,0,1; rs2 = 0.
  - STORE 0100011: 1,0,00,10,0,1,0; rd = 0.
  - BRANCH 1100011: 0,1,01,01,0,0,0; rd = 0.
  - LUI 0110111: 1,0,11,00,0,0,1; rs1 = rs2 = 0.
  - AUIPC 0010111: 1,0,00,00,0,0,1; rs1 = rs2 = 0.
  - JAL 1101111: 1,1,00,01,0,0,1; rs1 = rs2 = 0.
  - JALR 1100111: 1,1,00,01,0,0,1; rs2 = 0.
- **Immediates**, sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- **Illegal opcode** (any other opcode): o_illegal = 1, FUtype 11, all other controls 0, rs1/rs2/rd/imm 0. The instruction is still queued so it can trap in order.
- **x0-write suppression:** Regwrite is forced to 0 when rd == 0. rd is still reported as 0.
- **Payload outputs** (o_pc … o_funct7b5, o_illegal) are all 0 whenever o_valid = 0.

## Timing
- **Reset** (held): o_valid 0, i_ready 0, o_count 0, pointers 0, all payload 0. First cycle after release: i_ready 1.
- **Readiness:** i_ready = (o_count < DEPTH), derived from registers only. There is no combinational path from o_ready to i_ready.
- **Latency:** 1 cycle. An instruction pushed at edge N shows o_valid = 1 with its payload after edge N, provided the queue was empty.
- **Throughput:** 1 instruction/cycle with o_ready held high; simultaneous push and pop keep o_count unchanged.
- **Full** (o_count == DEPTH): i_ready = 0. A pop at edge N makes i_ready = 1 after edge N.
- **Empty:** o_valid = 0; o_ready is ignored.
- **Wrap-around:** head and tail pointers wrap modulo DEPTH. FIFO order is preserved across wrap.
- **Flush:** at edge N, o_count, head and tail are cleared; any push or pop in that cycle is discarded. After edge N: o_valid 0, i_ready 1.
- **Priority:** rst > flush > push/pop. rst asserted mid-stream clears everything identically to flush.
- **Output stability:** while o_valid && !o_ready, the head payload is held stable.

## Test plan
- **Basic decode:** push ADD x1,x2,x3 at PC 0, then ADDI x4,x5,100 at PC 4, with o_ready = 1.
  - ADD: rs1 2, rs2 3, rd 1, imm 0, ALUOp 10, FUtype 00, Regwrite 1.
  - ADDI: imm 100, ALUsrc 1.
  - Each appears one cycle after its push.
- **Full sweep:** push LW x6,8(x7); SW x8,12(x9); BEQ x10,x11,16; LUI x12,0x12345; AUIPC x13,0x1000; JAL x14,32; JALR x15,8(x16).
  - Expected immediates in order: 8, 12, 16, 0x12345000, 0x01000000, 32, 8.
  - Controls match the decode table; the SW and BEQ entries have rd 0.
  - Also check negative B/J immediates: BEQ with offset −4 gives imm 0xFFFFFFFC.
- **Backpressure:** o_ready = 0 while pushing 3 instructions with DEPTH = 2.
  - i_ready falls after 2 pushes; o_count = 2; the third instruction is held off by fetch.
  - Raise o_ready: order is PC 0, 4, 8, with no loss or duplication.
  - Repeat with DEPTH = 4, including pointer wrap.
- **Flush:** with 2 entries queued, assert flush for 1 cycle together with i_valid.
  - Next cycle: o_valid 0, o_count 0; the flushed-cycle instruction is absent.
  - The following push emerges normally.
- **Illegal opcode / x0:** push 0xFFFFFFFF → o_illegal 1, FUtype 11, all controls 0. Push ADDI x0,x1,5 → Regwrite 0, rd 0.
- **Reset mid-stream:** assert rst with the queue full → o_valid 0, i_ready 0 during reset; i_ready 1 after release; a subsequent push decodes correctly.
